// File: rtl/stack_arbiter2_if.sv
// Bus bundle for the two-client shared stack: per-client request/acknowledge
// channels plus the occupancy status of the stack.
interface stack_arbiter2_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  req0;
  logic                  op0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  err0;

  logic                  req1;
  logic                  op1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  err1;

  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;

  modport master (
    output req0, op0, wdata0, req1, op1, wdata1,
    input  gnt0, rdata0, err0, gnt1, rdata1, err1, count, empty, full
  );

  modport slave (
    input  req0, op0, wdata0, req1, op1, wdata1,
    output gnt0, rdata0, err0, gnt1, rdata1, err1, count, empty, full
  );
endinterface

// File: rtl/stack_arbiter2.sv
// Shared LIFO serving two requesters with round-robin arbitration, one
// operation per cycle, registered acknowledge carrying pop data and error.
module stack_arbiter2 #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  stack_arbiter2_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]         count;
  logic                  last_gnt;
  logic                  gnt0, gnt1, err0, err1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  logic                  elig0, elig1, grant0, grant1;
  logic                  sel_op, wr_en, err_n, is_full, is_empty;
  logic [DATA_WIDTH-1:0] sel_wdata, rdata_n;
  logic [CW-1:0]         count_n, count_m1;
  logic [AW-1:0]         widx, ridx;

  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);
  assign count_m1 = count - ONE;
  assign widx     = count[AW-1:0];
  assign ridx     = count_m1[AW-1:0];

  // A client acknowledged last cycle is masked so a held request is not served twice
  assign elig0 = bus.req0 && !gnt0;
  assign elig1 = bus.req1 && !gnt1;

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    wr_en     = 1'b0;
    err_n     = 1'b0;
    rdata_n   = '0;
    count_n   = count;
    if (elig0 && elig1) begin
      grant0 = last_gnt;
      grant1 = !last_gnt;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
    sel_op    = grant1 ? bus.op1    : bus.op0;
    sel_wdata = grant1 ? bus.wdata1 : bus.wdata0;
    if (grant0 || grant1) begin
      if (sel_op) begin
        if (!is_full) begin
          wr_en   = 1'b1;
          count_n = count + ONE;
        end else begin
          err_n = 1'b1;
        end
      end else begin
        if (!is_empty) begin
          rdata_n = mem[ridx];
          count_n = count_m1;
        end else begin
          err_n = 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; occupancy alone defines valid entries
  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= sel_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      last_gnt <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      count  <= count_n;
      gnt0   <= grant0;
      gnt1   <= grant1;
      err0   <= grant0 && err_n;
      err1   <= grant1 && err_n;
      rdata0 <= grant0 ? rdata_n : '0;
      rdata1 <= grant1 ? rdata_n : '0;
      if (grant0)      last_gnt <= 1'b0;
      else if (grant1) last_gnt <= 1'b1;
    end
  end

  assign bus.gnt0   = gnt0;
  assign bus.gnt1   = gnt1;
  assign bus.err0   = err0;
  assign bus.err1   = err1;
  assign bus.rdata0 = rdata0;
  assign bus.rdata1 = rdata1;
  assign bus.count  = count;
  assign bus.empty  = is_empty;
  assign bus.full   = is_full;
endmodule

// File: tb/tb_stack_arbiter2.sv
// Bench for stack_arbiter2: queue-based stack model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_stack_arbiter2;
  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_arbiter2_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  stack_arbiter2 #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] stk[$];
  logic          m_gnt0 = 1'b0, m_gnt1 = 1'b0, m_err0 = 1'b0, m_err1 = 1'b0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  int            m_last = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk.delete();
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_err0 = 1'b0; m_err1 = 1'b0;
      m_rd0 = '0; m_rd1 = '0; m_last = 1;
    end else begin
      bit e0, e1, g0, g1, op, er;
      logic [DW-1:0] wd, rd;
      e0 = bus.req0 && !m_gnt0;
      e1 = bus.req1 && !m_gnt1;
      if (e0 && e1) begin g0 = (m_last == 1); g1 = (m_last == 0); end
      else begin g0 = e0; g1 = e1; end
      rd = '0; er = 1'b0;
      if (g0 || g1) begin
        op = g0 ? bus.op0 : bus.op1;
        wd = g0 ? bus.wdata0 : bus.wdata1;
        if (op) begin
          if (stk.size() < DEPTH) stk.push_back(wd); else er = 1'b1;
        end else begin
          if (stk.size() > 0) rd = stk.pop_back(); else er = 1'b1;
        end
        m_last = g0 ? 0 : 1;
      end
      m_gnt0 = g0; m_gnt1 = g1;
      m_err0 = g0 && er; m_err1 = g1 && er;
      m_rd0 = g0 ? rd : '0; m_rd1 = g1 ? rd : '0;
    end
  end

  always @(negedge clk) begin
    check("gnt0",   32'(bus.gnt0),   32'(m_gnt0));
    check("gnt1",   32'(bus.gnt1),   32'(m_gnt1));
    check("rdata0", 32'(bus.rdata0), 32'(m_rd0));
    check("rdata1", 32'(bus.rdata1), 32'(m_rd1));
    check("err0",   32'(bus.err0),   32'(m_err0));
    check("err1",   32'(bus.err1),   32'(m_err1));
    check("count",  32'(bus.count),  32'(stk.size()));
    check("empty",  32'(bus.empty),  32'(stk.size() == 0));
    check("full",   32'(bus.full),   32'(stk.size() == DEPTH));
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int c, input bit r, input bit op, input logic [DW-1:0] d);
    if (c == 0) begin bus.req0 = r; bus.op0 = op; bus.wdata0 = d; end
    else        begin bus.req1 = r; bus.op1 = op; bus.wdata1 = d; end
  endtask

  task automatic do_op(input int c, input bit op, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd, output logic er);
    bit got = 1'b0;
    rd = '0; er = 1'b0;
    set_req(c, 1'b1, op, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (c == 0 ? bus.gnt0 : bus.gnt1) begin
        got = 1'b1;
        rd  = (c == 0) ? bus.rdata0 : bus.rdata1;
        er  = (c == 0) ? bus.err0   : bus.err1;
      end
    end
    set_req(c, 1'b0, 1'b0, '0);
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout: client %0d no gnt within 20 cycles (got 0, expected 1)", c);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd, rd_b;
    logic er, er_b;
    int prev;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_gnt0",  32'(bus.gnt0),  32'd0);

    // Test 1: push three, pop three on client 0
    do_op(0, 1'b1, 8'h11, rd, er); check("t1_push_err", 32'(er), 32'd0);
    do_op(0, 1'b1, 8'h22, rd, er);
    do_op(0, 1'b1, 8'h33, rd, er);
    check("t1_count3", 32'(bus.count), 32'd3);
    do_op(0, 1'b0, '0, rd, er); check("t1_pop_33", 32'(rd), 32'h33);
    do_op(0, 1'b0, '0, rd, er); check("t1_pop_22", 32'(rd), 32'h22);
    do_op(0, 1'b0, '0, rd, er); check("t1_pop_11", 32'(rd), 32'h11);
    check("t1_empty", 32'(bus.empty), 32'd1);

    // Test 2: simultaneous pushes from reset, client 0 wins first
    pulse_reset();
    fork
      do_op(0, 1'b1, 8'hA0, rd, er);
      do_op(1, 1'b1, 8'hB1, rd_b, er_b);
    join
    do_op(0, 1'b0, '0, rd, er); check("t2_pop_B1", 32'(rd), 32'hB1);
    do_op(1, 1'b0, '0, rd, er); check("t2_pop_A0", 32'(rd), 32'hA0);

    // Test 3: both held continuously, grants must alternate every cycle
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 8'h3C);
    set_req(1, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    prev = bus.gnt0 ? 0 : 1;
    check("t3_first_grant", 32'(bus.gnt0 ^ bus.gnt1), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("t3_one_grant", 32'(bus.gnt0 ^ bus.gnt1), 32'd1);
      check("t3_alternate", 32'(bus.gnt0 ? 0 : 1), 32'(1 - prev));
      prev = bus.gnt0 ? 0 : 1;
    end
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);

    // Test 4: fill, overflow push, pop top
    pulse_reset();
    for (int i = 1; i <= DEPTH; i++) do_op(i % 2, 1'b1, DW'(i), rd, er);
    check("t4_count8", 32'(bus.count), 32'd8);
    check("t4_full",   32'(bus.full),  32'd1);
    do_op(0, 1'b1, 8'hFF, rd, er);
    check("t4_ovf_err",   32'(er),        32'd1);
    check("t4_ovf_count", 32'(bus.count), 32'd8);
    do_op(1, 1'b0, '0, rd, er);
    check("t4_pop_8th", 32'(rd), 32'h08);
    check("t4_pop_err", 32'(er), 32'd0);

    // Test 5: underflow, then push/pop 0x5A
    pulse_reset();
    do_op(1, 1'b0, '0, rd, er);
    check("t5_unf_err",   32'(er),        32'd1);
    check("t5_unf_rdata", 32'(rd),        32'd0);
    check("t5_unf_count", 32'(bus.count), 32'd0);
    do_op(0, 1'b1, 8'h5A, rd, er);
    do_op(0, 1'b0, '0, rd, er);
    check("t5_pop_5A", 32'(rd), 32'h5A);

    // Test 6: async reset mid-cycle with a pending request
    for (int i = 0; i < 4; i++) do_op(0, 1'b1, DW'(8'h40 + i), rd, er);
    check("t6_count4", 32'(bus.count), 32'd4);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 8'h99);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", 32'(bus.count), 32'd0);
    check("t6_rst_gnt0",  32'(bus.gnt0),  32'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t6_no_gnt0", 32'(bus.gnt0), 32'd0);
    end
    do_op(1, 1'b1, 8'h77, rd, er);
    check("t6_push_err", 32'(er), 32'd0);
    do_op(1, 1'b0, '0, rd, er);
    check("t6_pop_77", 32'(rd), 32'h77);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
